// File: rtl/sramlike_bridge_ch_if.sv
// Signal bundle between a CPU sram-style port and the like-sram bus for one bridge channel.
// The slave modport is the bridge's view; the master modport is the CPU/bus environment's view.
interface sramlike_bridge_ch_if #(
    parameter int ADDR_W = 32
);
    logic              en;
    logic [3:0]        wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              cancel;
    logic              pipe_stall;
    logic              stall;
    logic              err;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;

    modport slave (
        input  en, wen, addr, wdata, cancel, pipe_stall,
        input  bus_rdata, bus_addr_ok, bus_data_ok,
        output rdata, stall, err,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );

    modport master (
        output en, wen, addr, wdata, cancel, pipe_stall,
        output bus_rdata, bus_addr_ok, bus_data_ok,
        input  rdata, stall, err,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );
endinterface

// File: rtl/sramlike_bridge_ch.sv
// Single-channel bridge: CPU sram-style access -> like-sram req/addr_ok/data_ok, with pipeline stall,
// read-data hold while the rest of the pipeline is frozen, and cancel of in-flight accesses.
//
// state | meaning
// IDLE  | no access in flight; accepts a new legal request
// REQ   | bus_req driven with latched address/data until addr_ok
// WAIT  | address accepted, waiting for data_ok
// HOLD  | access done but pipeline frozen elsewhere; rdata served from buffer
module sramlike_bridge_ch #(
    parameter int ADDR_W    = 32,
    parameter bit IS_INST   = 1'b0,
    parameter bit STRICT_BE = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    sramlike_bridge_ch_if.slave  s
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_abort;
    logic [31:0]       r_buf;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [1:0]        r_low;
    logic [ADDR_W-3:0] r_addr_hi;
    logic [31:0]       r_wdata;

    logic              w_legal;
    logic              w_wr;
    logic [1:0]        w_size;
    logic [1:0]        w_low;
    logic              w_accept;
    logic              w_done;
    logic              w_stall;
    logic              w_err;
    logic [31:0]       w_rdata;

    // Byte enables -> transfer size and low address bits; reads are always whole words.
    always_comb begin
        w_legal = 1'b1;
        w_wr    = 1'b0;
        w_size  = 2'd2;
        w_low   = 2'd0;
        if (!IS_INST) begin
            w_wr = |s.wen;
            case (s.wen)
                4'b0000: ;
                4'b0001: begin w_size = 2'd0; w_low = 2'd0; end
                4'b0010: begin w_size = 2'd0; w_low = 2'd1; end
                4'b0100: begin w_size = 2'd0; w_low = 2'd2; end
                4'b1000: begin w_size = 2'd0; w_low = 2'd3; end
                4'b0011: begin w_size = 2'd1; w_low = 2'd0; end
                4'b1100: begin w_size = 2'd1; w_low = 2'd2; end
                4'b1111: ;
                default: begin
                    if (STRICT_BE) begin
                        w_legal = 1'b0;
                    end else if (s.wen[0]) begin
                        w_low = 2'd0;
                    end else if (s.wen[1]) begin
                        w_low = 2'd1;
                    end else if (s.wen[2]) begin
                        w_low = 2'd2;
                    end else begin
                        w_low = 2'd3;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_abort   <= 1'b0;
            r_buf     <= 32'd0;
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            r_low     <= 2'd0;
            r_addr_hi <= '0;
            r_wdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_wr      <= w_wr;
                r_size    <= w_size;
                r_low     <= w_low;
                r_addr_hi <= s.addr[ADDR_W-1:2];
                r_wdata   <= s.wdata;
            end
            if ((r_state == ST_REQ || r_state == ST_WAIT) && s.cancel) begin
                r_abort <= 1'b1;
            end
            if (r_state == ST_WAIT && s.bus_data_ok) begin
                r_buf   <= s.bus_rdata;
                r_abort <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = (r_state == ST_IDLE) && s.en && !s.cancel && w_legal;
        w_done   = ((r_state == ST_WAIT) && s.bus_data_ok && !r_abort) || (r_state == ST_HOLD);
        w_err    = resetn && (r_state == ST_IDLE) && s.en && !w_legal;
        // An illegal request is rejected by err, so it must not also freeze the pipeline.
        w_stall  = resetn && s.en && !s.cancel && !w_done &&
                   !((r_state == ST_IDLE) && !w_legal);
        w_rdata  = ((r_state == ST_WAIT) && s.bus_data_ok) ? s.bus_rdata : r_buf;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ:  if (s.bus_addr_ok) w_next = ST_WAIT;
            ST_WAIT: begin
                if (s.bus_data_ok) begin
                    w_next = (s.pipe_stall && !(r_abort || s.cancel)) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: if (!s.pipe_stall) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign s.stall     = w_stall;
    assign s.err       = w_err;
    assign s.rdata     = w_rdata;
    assign s.bus_req   = (r_state == ST_REQ);
    assign s.bus_wr    = r_wr;
    assign s.bus_size  = r_size;
    assign s.bus_addr  = {r_addr_hi, r_low};
    assign s.bus_wdata = r_wdata;
endmodule
